// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/redirect sequencing for a 5-stage RV32I pipeline
// Inputs : ID register-use info (id_rs*), EX load/jump status (ex_*),
//          MEM data-memory handshake (dmem_req_i, dmem_ready_i)
// Outputs: stall_* hold PC and pipeline registers, flush_* insert NOPs,
//          jump_en_o/jump_addr_o redirect the PC, mem_err_o flags a sticky
//          data-memory timeout, stall_cycles_o counts PC-stall cycles
module hazard_ctrl #(
   parameter int IMEM_LAT    = 1,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1_addr_i,
   input  logic [4:0]       id_rs2_addr_i,
   input  logic             id_rs1_used_i,
   input  logic             id_rs2_used_i,
   input  logic             ex_mem_re_i,
   input  logic [4:0]       ex_rd_addr_i,
   input  logic             ex_jump_en_i,
   input  logic [31:0]      ex_jump_addr_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ready_i,
   output logic             stall_pc_o,
   output logic             stall_if_id_o,
   output logic             stall_id_ex_o,
   output logic             stall_ex_mem_o,
   output logic             flush_if_id_o,
   output logic             flush_id_ex_o,
   output logic             jump_en_o,
   output logic [31:0]      jump_addr_o,
   output logic             mem_err_o,
   output logic [CNT_W-1:0] stall_cycles_o
);
   typedef enum logic [1:0] {RUN, FLUSH, WAIT} state_t;
   localparam logic [2:0]  FL_INIT = 3'(IMEM_LAT > 0 ? IMEM_LAT - 1 : 0);
   localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   state_t           state_q, state_d;
   logic [2:0]       fl_cnt_q, fl_cnt_d;
   logic [15:0]      wait_cnt_q, wait_cnt_d;
   logic             abort_q, abort_d;
   logic             ret_flush_q, ret_flush_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic             w, lu, timeout;
   // abort masks the wait for one cycle after a timeout so the pipeline can drain
   assign w  = dmem_req_i & ~dmem_ready_i & ~abort_q;
   assign lu = ex_mem_re_i & (ex_rd_addr_i != 5'd0) &
               ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));
   assign timeout = w & (wait_cnt_q == TO_LAST);
   always_comb begin
      stall_pc_o     = 1'b0;
      stall_if_id_o  = 1'b0;
      stall_id_ex_o  = 1'b0;
      stall_ex_mem_o = 1'b0;
      flush_if_id_o  = 1'b0;
      flush_id_ex_o  = 1'b0;
      jump_en_o      = 1'b0;
      jump_addr_o    = 32'd0;
      if (!rst) begin
         if (w) begin
            stall_pc_o     = 1'b1;
            stall_if_id_o  = 1'b1;
            stall_id_ex_o  = 1'b1;
            stall_ex_mem_o = 1'b1;
         end else if (ex_jump_en_i) begin
            jump_en_o     = 1'b1;
            jump_addr_o   = ex_jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
         end else if (lu) begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
         end else if (state_q == FLUSH) begin
            flush_if_id_o = 1'b1;
         end
      end
   end
   always_comb begin
      state_d        = state_q;
      fl_cnt_d       = fl_cnt_q;
      ret_flush_d    = ret_flush_q;
      wait_cnt_d     = w ? wait_cnt_q + 16'd1 : 16'd0;
      abort_d        = timeout;
      mem_err_d      = mem_err_q | timeout;
      stall_cycles_d = (stall_pc_o && !(&stall_cycles_q)) ? stall_cycles_q + CNT_ONE : stall_cycles_q;
      case (state_q)
         RUN: begin
            if (w) begin
               state_d     = WAIT;
               ret_flush_d = 1'b0;
            end else if (ex_jump_en_i && IMEM_LAT > 0) begin
               state_d  = FLUSH;
               fl_cnt_d = FL_INIT;
            end
         end
         FLUSH: begin
            if (w) begin
               state_d     = WAIT;
               ret_flush_d = 1'b1;
            end else if (ex_jump_en_i) fl_cnt_d = FL_INIT;
            else if (fl_cnt_q == 3'd0) state_d = RUN;
            else fl_cnt_d = fl_cnt_q - 3'd1;
         end
         WAIT: if (!w) state_d = ret_flush_q ? FLUSH : RUN;
         default: state_d = RUN;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= RUN;
         fl_cnt_q       <= 3'd0;
         wait_cnt_q     <= 16'd0;
         abort_q        <= 1'b0;
         ret_flush_q    <= 1'b0;
         mem_err_q      <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         fl_cnt_q       <= fl_cnt_d;
         wait_cnt_q     <= wait_cnt_d;
         abort_q        <= abort_d;
         ret_flush_q    <= ret_flush_d;
         mem_err_q      <= mem_err_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end
   assign mem_err_o      = mem_err_q;
   assign stall_cycles_o = stall_cycles_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (IMEM_LAT=1, MEM_TIMEOUT=4, CNT_W=8)
module tb_hazard_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1, rs2, rd;
   logic        u1, u2, mre, je, req, rdy;
   logic [31:0] ja;
   logic        spc, sifid, sidex, sexm, fifid, fidex, jen, err;
   logic [31:0] jad;
   logic [7:0]  sc;
   int          total = 0, bad = 0;
   logic [47:0] exp_q[$];
   string       tag_q[$];
   logic        e_err = 1'b0;
   logic [7:0]  e_sc = 8'd0;
   // expected control bits: {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, jump_en}
   localparam logic [6:0] C_0 = 7'b0000000, C_LU = 7'b1100010, C_J = 7'b0000111,
                          C_FL = 7'b0000100, C_W = 7'b1111000;
   hazard_ctrl #(.IMEM_LAT(1), .MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
      .ex_mem_re_i(mre), .ex_rd_addr_i(rd), .ex_jump_en_i(je), .ex_jump_addr_i(ja),
      .dmem_req_i(req), .dmem_ready_i(rdy),
      .stall_pc_o(spc), .stall_if_id_o(sifid), .stall_id_ex_o(sidex), .stall_ex_mem_o(sexm),
      .flush_if_id_o(fifid), .flush_id_ex_o(fidex), .jump_en_o(jen), .jump_addr_o(jad),
      .mem_err_o(err), .stall_cycles_o(sc)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got ctl=%b addr=%h err=%b sc=%0d, want ctl=%b addr=%h err=%b sc=%0d",
                  tag, got[47:41], got[40:9], got[8], got[7:0], exp[47:41], exp[40:9], exp[8], exp[7:0]);
      end
   endtask
   always @(negedge clk) begin
      if (exp_q.size() > 0)
         check(tag_q.pop_front(), {spc, sifid, sidex, sexm, fifid, fidex, jen, jad, err, sc}, exp_q.pop_front());
   end
   // push expectation for the cycle being driven, then advance one clock
   task automatic cyc(input string tag, input logic [6:0] ctl, input logic [31:0] addr, input logic set_err);
      exp_q.push_back({ctl, addr, e_err, e_sc});
      tag_q.push_back(tag);
      if (rst) begin
         e_err = 1'b0;
         e_sc  = 8'd0;
      end else begin
         e_err = e_err | set_err;
         if (ctl[6] && e_sc != 8'hff) e_sc = e_sc + 8'd1;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mre = 0; je = 0; ja = 0; req = 0; rdy = 0;
   endtask
   initial begin
      rst = 1'b1;
      idle();
      @(posedge clk);
      #1;
      cyc("reset", C_0, 0, 0);
      rst = 1'b0;
      cyc("idle", C_0, 0, 0);
      mre = 1; rd = 5; u1 = 1; rs1 = 5;
      cyc("lu_rs1", C_LU, 0, 0);
      idle();
      cyc("lu_release", C_0, 0, 0);
      mre = 1; rd = 0; u1 = 1; rs1 = 0;
      cyc("lu_rd0", C_0, 0, 0);
      rd = 5; rs1 = 5; u1 = 0;
      cyc("lu_unused", C_0, 0, 0);
      u2 = 1; rs2 = 7; rd = 7;
      cyc("lu_rs2", C_LU, 0, 0);
      rs2 = 6;
      cyc("lu_rs2_miss", C_0, 0, 0);
      rs2 = 7; mre = 0;
      cyc("lu_not_load", C_0, 0, 0);
      idle();
      je = 1; ja = 32'h100;
      cyc("jump", C_J, 32'h100, 0);
      idle();
      cyc("jump_flush", C_FL, 0, 0);
      cyc("jump_done", C_0, 0, 0);
      je = 1; ja = 32'h200; mre = 1; rd = 3; u1 = 1; rs1 = 3;
      cyc("jump_vs_lu", C_J, 32'h200, 0);
      idle();
      cyc("jlu_flush", C_FL, 0, 0);
      cyc("jlu_done", C_0, 0, 0);
      je = 1; ja = 32'h400;
      cyc("jump_a", C_J, 32'h400, 0);
      ja = 32'h404;
      cyc("jump_b", C_J, 32'h404, 0);
      idle();
      cyc("rejump_flush", C_FL, 0, 0);
      cyc("rejump_done", C_0, 0, 0);
      je = 1; ja = 32'h500;
      cyc("jump_c", C_J, 32'h500, 0);
      idle();
      mre = 1; rd = 9; u2 = 1; rs2 = 9;
      cyc("lu_in_flush", C_LU, 0, 0);
      idle();
      cyc("lu_flush_done", C_0, 0, 0);
      req = 1;
      for (int i = 0; i < 3; i++) cyc("wait", C_W, 0, 0);
      rdy = 1;
      cyc("wait_ready", C_0, 0, 0);
      idle();
      cyc("wait_after", C_0, 0, 0);
      req = 1; je = 1; ja = 32'h300;
      for (int i = 0; i < 3; i++) cyc("wait_jump", C_W, 0, 0);
      rdy = 1;
      cyc("wait_jump_ready", C_J, 32'h300, 0);
      idle();
      cyc("wait_jump_after", C_0, 0, 0);
      je = 1; ja = 32'h600;
      cyc("jump_d", C_J, 32'h600, 0);
      idle();
      req = 1;
      cyc("flush_wait", C_W, 0, 0);
      rdy = 1;
      cyc("flush_wait_ready", C_0, 0, 0);
      idle();
      cyc("flush_resume", C_FL, 0, 0);
      cyc("flush_resume_done", C_0, 0, 0);
      req = 1;
      for (int i = 0; i < 4; i++) cyc("to_wait", C_W, 0, i == 3);
      cyc("to_abort", C_0, 0, 0);
      cyc("to_resume", C_W, 0, 0);
      idle();
      cyc("to_release", C_0, 0, 0);
      cyc("to_sticky", C_0, 0, 0);
      req = 1;
      cyc("rst_wait1", C_W, 0, 0);
      rst = 1;
      cyc("rst_mid_wait", C_0, 0, 0);
      rst = 0;
      idle();
      cyc("after_rst", C_0, 0, 0);
      req = 1;
      for (int i = 0; i < 320; i++) cyc("sat", (i % 5 == 4) ? C_0 : C_W, 0, (i % 5 == 3));
      idle();
      cyc("sat_final", C_0, 0, 0);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard/sequencing controller for the 5-stage RV32I core: IF, ID, EX, MEM, WB.
- Takes register-use info from decode, load/jump status from EX, and data-memory handshake from MEM.
- Drives the hold (stall) and bubble (flush) controls of the PC and the if_id / id_ex / ex_mem pipeline registers, plus the PC redirect.
- Owns the jump-flush sequencing, the data-memory wait/timeout FSM and a stall performance counter.

Parameters:
- IMEM_LAT, 1: extra cycles if_id is flushed after a redirect, covering synchronous instruction-memory latency; range 0..7.
- MEM_TIMEOUT, 255: maximum consecutive data-memory wait cycles before abort; range 1..65535.
- CNT_W, 32: stall performance counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- id_rs1_addr_i  in  5  rs1 index of the instruction in ID.
- id_rs2_addr_i  in  5  rs2 index of the instruction in ID.
- id_rs1_used_i  in  1  ID instruction reads rs1.
- id_rs2_used_i  in  1  ID instruction reads rs2.
- ex_mem_re_i  in  1  instruction in EX is a load.
- ex_rd_addr_i  in  5  destination of the instruction in EX.
- ex_jump_en_i  in  1  EX resolved a taken branch/jump.
- ex_jump_addr_i  in  32  target of that branch/jump.
- dmem_req_i  in  1  MEM stage is accessing data memory.
- dmem_ready_i  in  1  data memory completes this cycle.
- stall_pc_o  out  1  hold PC.
- stall_if_id_o  out  1  hold if_id.
- stall_id_ex_o  out  1  hold id_ex.
- stall_ex_mem_o  out  1  hold ex_mem.
- flush_if_id_o  out  1  load NOP into if_id.
- flush_id_ex_o  out  1  load NOP into id_ex.
- jump_en_o  out  1  PC redirect strobe.
- jump_addr_o  out  32  redirect target.
- mem_err_o  out  1  sticky data-memory timeout flag.
- stall_cycles_o  out  CNT_W  count of cycles with stall_pc_o=1.

Behaviour:
- Reset (rst=1 at an edge): state=RUN; fl_cnt=0; wait_cnt=0; abort=0; ret_flush=0; mem_err_o=0; stall_cycles_o=0.
- While rst=1 all combinational outputs are 0, including jump_addr_o.
- Reset mid-wait or mid-flush discards all progress.
- Definitions:
  - W = dmem_req_i & ~dmem_ready_i & ~abort.
  - LU = ex_mem_re_i & (ex_rd_addr_i!=0) & ((id_rs1_used_i & id_rs1_addr_i==ex_rd_addr_i) | (id_rs2_used_i & id_rs2_addr_i==ex_rd_addr_i)).
- Combinational outputs, priority W > jump > LU:
  - W=1: all four stall_* =1; flush_* =0; jump_en_o=0.
  - Else ex_jump_en_i=1: jump_en_o=1; jump_addr_o=ex_jump_addr_i; flush_if_id_o=1; flush_id_ex_o=1; no stalls.
  - Else LU=1: stall_pc_o=1; stall_if_id_o=1; flush_id_ex_o=1, giving exactly one bubble. The load then forwards from MEM.
  - Else in state FLUSH: flush_if_id_o=1.
  - jump_addr_o = 0 whenever jump_en_o=0.
- FSM states RUN, FLUSH, WAIT (registered):
  - RUN: W → WAIT with ret_flush=0. Else jump with IMEM_LAT>0 → FLUSH with fl_cnt=IMEM_LAT-1. Else stay.
  - FLUSH: W → WAIT with ret_flush=1; fl_cnt frozen. Else jump → reload fl_cnt=IMEM_LAT-1 and stay. Else fl_cnt==0 → RUN. Else decrement fl_cnt.
  - WAIT: W=0 → return to FLUSH if ret_flush, else RUN. The release cycle evaluates jump/LU normally, so a jump held in EX during the wait is taken in the dmem_ready_i cycle.
- Timeout:
  - wait_cnt increments on every W cycle and clears on any non-W cycle.
  - On a W cycle with wait_cnt==MEM_TIMEOUT-1: mem_err_o←1 (sticky until rst) and abort←1.
  - abort forces W=0 for exactly the next cycle, then self-clears. Stalls therefore last at most MEM_TIMEOUT consecutive cycles.
- stall_cycles_o increments at each edge where stall_pc_o=1 and saturates at all-ones.
- A new jump seen in FLUSH restarts the flush count.

Test Plan:
- Load-use: ex_mem_re_i=1, ex_rd_addr_i=5, id_rs1_used_i=1, id_rs1_addr_i=5 for 1 cycle → stall_pc_o=1, stall_if_id_o=1, flush_id_ex_o=1 for exactly 1 cycle; stall_cycles_o=1. Repeat with ex_rd_addr_i=0, or id_rs1_used_i=0 → no stall.
- Jump, IMEM_LAT=1: ex_jump_en_i=1, ex_jump_addr_i=0x0000_0100 for 1 cycle → that cycle jump_en_o=1, jump_addr_o=0x100, both flushes=1; next cycle flush_if_id_o=1 only; then all 0.
- Jump and load-use in the same cycle → jump wins: no stall, both flushes=1.
- Memory wait: dmem_req_i=1, dmem_ready_i=0 for 3 cycles, then ready → all four stalls=1 for 3 cycles, released in the ready cycle; a jump held during the wait gives jump_en_o=1 in the ready cycle only.
- Timeout, MEM_TIMEOUT=4: dmem_req_i=1, dmem_ready_i=0 held → stalls for 4 cycles, 5th cycle stalls=0, mem_err_o=1 from the 5th cycle on; stalls resume in the 6th cycle if still waiting; mem_err_o stays 1 until rst.
- Reset mid-wait: rst=1 on the 2nd wait cycle → next cycle all outputs 0, stall_cycles_o=0, state RUN.
